// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: answers the core's dreq/dresp handshake from a local
// word-addressed SRAM with a fixed LATENCY (1..15 cycles).
// Optional protocol checker: define DBUS_RESP_CHECK_EN to add the sticky
// proto_err output (and a simulation $error) for unstable or illegal requests.

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned AW      = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        busy,
  output logic [31:0] txn_cnt
`ifdef DBUS_RESP_CHECK_EN
  ,
  output logic        proto_err
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic [31:0] txn_cnt_q, txn_cnt_d;
  dbus_resp_t  dresp_q, dresp_d;
  logic [AW-1:0] rd_idx;
  logic [63:0] rd_word;
  logic [63:0] mem_q [2**AW];

  // size and the out-of-window address bits do not steer the data path
  logic unused_req;
  assign unused_req = ^{dreq.size, dreq.addr[63:AW+3], dreq.addr[2:0]};

  // Next-state logic: latch the request in IDLE, count down in WAIT, and
  // register the pre-write word as the response when entering RESP
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    strobe_d  = strobe_q;
    wdata_d   = wdata_q;
    txn_cnt_d = txn_cnt_q;
    dresp_d   = '0;
    rd_idx    = (state_q == IDLE) ? dreq.addr[AW+2:3] : idx_q;
    rd_word   = mem_q[rd_idx];
    unique case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          idx_d    = dreq.addr[AW+2:3];
          strobe_d = dreq.strobe;
          wdata_d  = dreq.data;
          cnt_d    = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            dresp_d = '{addr_ok: 1'b1, data_ok: 1'b1, data: rd_word};
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // the wait cycle whose decremented count reaches zero is the last one
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          dresp_d = '{addr_ok: 1'b1, data_ok: 1'b1, data: rd_word};
        end
      end
      RESP: begin
        txn_cnt_d = txn_cnt_q + 32'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      strobe_q  <= '0;
      wdata_q   <= '0;
      txn_cnt_q <= '0;
      dresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      wdata_q   <= wdata_d;
      txn_cnt_q <= txn_cnt_d;
      dresp_q   <= dresp_d;
    end
  end

  // Byte-lane write at the edge that ends RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (state_q == RESP) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign dresp   = dresp_q;
  assign busy    = (state_q != IDLE);
  assign txn_cnt = txn_cnt_q;

`ifdef DBUS_RESP_CHECK_EN
  logic [63:0] addr_q, addr_d;
  logic        proto_err_q, proto_err_d;
  logic [7:0]  size_mask;
  logic [15:0] lane_window;
  logic        wait_err, idle_err;

  // Checker: request must stay stable through WAIT and strobes must fit size/offset
  always_comb begin
    addr_d = addr_q;
    if (state_q == IDLE && dreq.valid) addr_d = dreq.addr;
    case (dreq.size)
      3'd0:    size_mask = 8'h01;
      3'd1:    size_mask = 8'h03;
      3'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    lane_window = {8'h00, size_mask} << dreq.addr[2:0];
    wait_err = (state_q == WAIT) &&
               (!dreq.valid || dreq.addr != addr_q ||
                dreq.strobe != strobe_q || dreq.data != wdata_q);
    idle_err = (state_q == IDLE) && dreq.valid &&
               ((dreq.strobe & ~lane_window[7:0]) != 8'h00);
    proto_err_d = proto_err_q | wait_err | idle_err;
  end

  // Sticky error flag and latched full address for the stability check
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

`ifndef SYNTHESIS
  // Simulation-only report of each protocol violation as it is flagged
  always @(posedge clk) begin
    if (reset && (wait_err || idle_err))
      $error("dbus_sram_responder: protocol violation (wait=%0b idle=%0b)", wait_err, idle_err);
  end
`endif
`endif

endmodule
